// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg: shared state/access encodings and routing helper
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, STROBE, HOLD} state_t;
    typedef enum logic [1:0] {ACC_FETCH, ACC_READ, ACC_WRITE} acc_t;

    function automatic logic is_int(input logic [15:0] a, input int aw);
        return (a >> aw) == 16'd0;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: core-side fetch/read/write request bus
interface mem_bus_ctrl_if;

    logic        rom_en;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ready;
    logic        ram_rd_en;
    logic [15:0] ram_rd_addr;
    logic [7:0]  ram_rd_data;
    logic        ram_rd_ready;
    logic        ram_wr_en;
    logic [15:0] ram_wr_addr;
    logic [7:0]  ram_wr_data;
    logic        ram_wr_ready;
    logic        busy;

    modport master (
        output rom_en, rom_addr, ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data,
        input  rom_data, rom_ready, ram_rd_data, ram_rd_ready, ram_wr_ready, busy
    );

    modport slave (
        input  rom_en, rom_addr, ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data,
        output rom_data, rom_ready, ram_rd_data, ram_rd_ready, ram_wr_ready, busy
    );

endinterface

// File: rtl/mem_bus_ctrl_ext_bus_seq.sv
// ext_bus_seq: multiplexed external bus sequencer (ADDR, STROBE with wait states, HOLD)
module ext_bus_seq
    import mem_bus_ctrl_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  acc_t        acc_in,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output acc_t        acc,
    output logic        busy,
    output logic        done,
    output logic        sample,
    output logic        ale,
    output logic        p0_oe,
    output logic [7:0]  p0_out,
    output logic [7:0]  p2_out,
    output logic        psen_n,
    output logic        rd_n,
    output logic        wr_n
);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [15:0] a_q;
    logic [7:0]  d_q;
    logic        wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            d_q   <= '0;
            acc   <= ACC_FETCH;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (start) begin
                a_q <= addr;
                d_q <= wdata;
                acc <= acc_in;
            end
        end
    end

    assign wr = acc == ACC_WRITE;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        busy    = state != IDLE;
        done    = state == HOLD;
        sample  = 1'b0;
        ale     = 1'b0;
        p0_oe   = 1'b0;
        p0_out  = '0;
        p2_out  = a_q[15:8];
        psen_n  = 1'b1;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        case (state)
            IDLE: state_n = start ? ADDR : IDLE;
            ADDR: begin
                ale     = 1'b1;
                p0_oe   = 1'b1;
                p0_out  = a_q[7:0];
                cnt_n   = 4'(WAIT_STATES);
                state_n = STROBE;
            end
            STROBE: begin
                psen_n  = acc != ACC_FETCH;
                rd_n    = acc != ACC_READ;
                wr_n    = !wr;
                p0_oe   = wr;
                p0_out  = wr ? d_q : '0;
                // read data is taken on the final strobe cycle so slow devices get every wait state
                sample  = cnt == 4'd0 && !wr;
                cnt_n   = cnt == 4'd0 ? cnt : cnt - 4'd1;
                state_n = cnt == 4'd0 ? HOLD : STROBE;
            end
            HOLD: begin
                p0_oe   = wr;
                p0_out  = wr ? d_q : '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: arbitrates core fetch/read/write and routes to internal ROM/RAM or the external bus
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int INT_ROM_AW  = 12,
    parameter int INT_RAM_AW  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_bus_ctrl_if.slave         bus,
    output logic                  irom_en,
    output logic [INT_ROM_AW-1:0] irom_addr,
    input  logic [7:0]            irom_data,
    output logic                  iram_rd_en,
    output logic [INT_RAM_AW-1:0] iram_rd_addr,
    input  logic [7:0]            iram_rd_data,
    output logic                  iram_wr_en,
    output logic [INT_RAM_AW-1:0] iram_wr_addr,
    output logic [7:0]            iram_wr_data,
    input  logic                  ea_n,
    input  logic [7:0]            p0_in,
    output logic [7:0]            p0_out,
    output logic                  p0_oe,
    output logic [7:0]            p2_out,
    output logic                  ale,
    output logic                  psen_n,
    output logic                  rd_n,
    output logic                  wr_n
);

    acc_t        acc_sel, acc_cur;
    logic [15:0] addr;
    logic        go, int_hit, start, seq_busy, done, sample;
    logic        f_q, r_q, w_q;
    logic [7:0]  rd_q;

    always_comb begin
        acc_sel      = bus.ram_wr_en ? ACC_WRITE : bus.ram_rd_en ? ACC_READ : ACC_FETCH;
        addr         = acc_sel == ACC_WRITE ? bus.ram_wr_addr :
                       acc_sel == ACC_READ  ? bus.ram_rd_addr : bus.rom_addr;
        int_hit      = acc_sel == ACC_FETCH ? ea_n && is_int(addr, INT_ROM_AW) : is_int(addr, INT_RAM_AW);
        // requests stay asserted during their ready cycle, so a pending internal ready blocks re-acceptance
        go           = !rst && !seq_busy && !(f_q || r_q || w_q) &&
                       (bus.ram_wr_en || bus.ram_rd_en || bus.rom_en);
        start        = go && !int_hit;
        irom_en      = go && int_hit && acc_sel == ACC_FETCH;
        iram_rd_en   = go && int_hit && acc_sel == ACC_READ;
        iram_wr_en   = go && int_hit && acc_sel == ACC_WRITE;
        irom_addr    = irom_en ? bus.rom_addr[INT_ROM_AW-1:0] : '0;
        iram_rd_addr = iram_rd_en ? bus.ram_rd_addr[INT_RAM_AW-1:0] : '0;
        iram_wr_addr = iram_wr_en ? bus.ram_wr_addr[INT_RAM_AW-1:0] : '0;
        iram_wr_data = iram_wr_en ? bus.ram_wr_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q  <= 1'b0;
            r_q  <= 1'b0;
            w_q  <= 1'b0;
            rd_q <= '0;
        end else begin
            f_q <= irom_en;
            r_q <= iram_rd_en;
            w_q <= iram_wr_en;
            if (irom_en)
                rd_q <= irom_data;
            else if (sample)
                rd_q <= p0_in;
        end
    end

    assign bus.rom_ready    = f_q || (done && acc_cur == ACC_FETCH);
    assign bus.ram_rd_ready = r_q || (done && acc_cur == ACC_READ);
    assign bus.ram_wr_ready = w_q || (done && acc_cur == ACC_WRITE);
    assign bus.rom_data     = rd_q;
    assign bus.ram_rd_data  = r_q ? iram_rd_data : rd_q;
    assign bus.busy         = seq_busy;

    ext_bus_seq #(.WAIT_STATES(WAIT_STATES)) u_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .acc_in (acc_sel),
        .addr   (addr),
        .wdata  (bus.ram_wr_data),
        .acc    (acc_cur),
        .busy   (seq_busy),
        .done   (done),
        .sample (sample),
        .ale    (ale),
        .p0_oe  (p0_oe),
        .p0_out (p0_out),
        .p2_out (p2_out),
        .psen_n (psen_n),
        .rd_n   (rd_n),
        .wr_n   (wr_n)
    );

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: scenario tasks plus randomized traffic against a memory-map reference model
module tb_mem_bus_ctrl;

    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   ovl = 0;
    int   irom_seen = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl_if bus ();
    mem_bus_ctrl_if b0 ();

    logic        irom_en, iram_rd_en, iram_wr_en, ea_n, p0_oe, ale, psen_n, rd_n, wr_n;
    logic [11:0] irom_addr;
    logic [7:0]  irom_data, iram_rd_addr, iram_rd_data, iram_wr_addr, iram_wr_data;
    logic [7:0]  p0_in, p0_out, p2_out;

    logic        z_irom_en, z_iram_rd_en, z_iram_wr_en, z_p0_oe, z_ale, z_psen_n, z_rd_n, z_wr_n;
    logic [11:0] z_irom_addr;
    logic [7:0]  z_iram_rd_addr, z_iram_wr_addr, z_iram_wr_data, z_p0_in, z_p0_out, z_p2_out;

    mem_bus_ctrl #(.INT_ROM_AW(12), .INT_RAM_AW(8), .WAIT_STATES(W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .irom_en(irom_en), .irom_addr(irom_addr), .irom_data(irom_data),
        .iram_rd_en(iram_rd_en), .iram_rd_addr(iram_rd_addr), .iram_rd_data(iram_rd_data),
        .iram_wr_en(iram_wr_en), .iram_wr_addr(iram_wr_addr), .iram_wr_data(iram_wr_data),
        .ea_n(ea_n), .p0_in(p0_in), .p0_out(p0_out), .p0_oe(p0_oe), .p2_out(p2_out),
        .ale(ale), .psen_n(psen_n), .rd_n(rd_n), .wr_n(wr_n)
    );

    mem_bus_ctrl #(.INT_ROM_AW(12), .INT_RAM_AW(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0),
        .irom_en(z_irom_en), .irom_addr(z_irom_addr), .irom_data(8'h00),
        .iram_rd_en(z_iram_rd_en), .iram_rd_addr(z_iram_rd_addr), .iram_rd_data(8'h00),
        .iram_wr_en(z_iram_wr_en), .iram_wr_addr(z_iram_wr_addr), .iram_wr_data(z_iram_wr_data),
        .ea_n(1'b1), .p0_in(z_p0_in), .p0_out(z_p0_out), .p0_oe(z_p0_oe), .p2_out(z_p2_out),
        .ale(z_ale), .psen_n(z_psen_n), .rd_n(z_rd_n), .wr_n(z_wr_n)
    );

    function automatic logic [7:0] rom_fn(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ext_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // memories attached to the DUT pins
    logic [7:0]  iram [0:255];
    logic [7:0]  ext_mem [0:65535];
    logic [15:0] lat = '0;
    logic [15:0] z_lat = '0;

    assign irom_data = rom_fn(irom_addr);
    assign p0_in     = (!rd_n || !psen_n) ? ext_mem[lat] : 8'hEE;
    assign z_p0_in   = (!z_rd_n || !z_psen_n) ? ext_fn(z_lat) : 8'hEE;

    always @(posedge clk) begin
        if (iram_wr_en) iram[iram_wr_addr] <= iram_wr_data;
        if (iram_rd_en) iram_rd_data <= iram[iram_rd_addr];
        if (ale) lat <= {p2_out, p0_out};
        if (!wr_n) ext_mem[lat] <= p0_out;
        if (z_ale) z_lat <= {z_p2_out, z_p0_out};
    end

    always @(negedge clk) begin
        if (!rst) begin
            if ($countones({~psen_n, ~rd_n, ~wr_n}) > 1 || (ale && !(psen_n && rd_n && wr_n))) ovl++;
            if ($countones({~z_psen_n, ~z_rd_n, ~z_wr_n}) > 1) ovl++;
            if (irom_en) irom_seen++;
        end
    end

    // reference model: what each address of the memory map should hold
    logic [7:0] ref_iram [0:255];
    logic [7:0] ref_ext [logic [15:0]];

    function automatic logic [7:0] ref_ext_rd(input logic [15:0] a);
        return ref_ext.exists(a) ? ref_ext[a] : ext_fn(a);
    endfunction

    task automatic do_acc(input int kind, input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] got, output int lat_c);
        @(posedge clk); #1;
        if (kind == 0) begin bus.rom_en = 1'b1; bus.rom_addr = a; end
        if (kind == 1) begin bus.ram_rd_en = 1'b1; bus.ram_rd_addr = a; end
        if (kind == 2) begin bus.ram_wr_en = 1'b1; bus.ram_wr_addr = a; bus.ram_wr_data = d; end
        lat_c = 0;
        got = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if ((kind == 0 && bus.rom_ready) || (kind == 1 && bus.ram_rd_ready) || (kind == 2 && bus.ram_wr_ready)) begin
                lat_c = i;
                break;
            end
        end
        got = kind == 0 ? bus.rom_data : bus.ram_rd_data;
        bus.rom_en = 1'b0;
        bus.ram_rd_en = 1'b0;
        bus.ram_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.rom_ready, bus.ram_rd_ready, bus.ram_wr_ready, bus.busy} !== 4'b0) begin
            bad++; $display("FAIL reset_ready got=%b exp=0000", {bus.rom_ready, bus.ram_rd_ready, bus.ram_wr_ready, bus.busy});
        end
        total++;
        if ({irom_en, iram_rd_en, iram_wr_en, ale, p0_oe} !== 5'b0) begin
            bad++; $display("FAIL reset_en got=%b exp=00000", {irom_en, iram_rd_en, iram_wr_en, ale, p0_oe});
        end
        total++;
        if ({psen_n, rd_n, wr_n, z_psen_n, z_rd_n, z_wr_n} !== 6'b111111) begin
            bad++; $display("FAIL reset_strobes got=%b exp=111111", {psen_n, rd_n, wr_n, z_psen_n, z_rd_n, z_wr_n});
        end
        total++;
        if ({p0_out, p2_out, bus.rom_data, bus.ram_rd_data} !== 32'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", {p0_out, p2_out, bus.rom_data, bus.ram_rd_data});
        end
        total++;
        if ({irom_addr, iram_rd_addr, iram_wr_addr, iram_wr_data} !== 36'h0) begin
            bad++; $display("FAIL reset_iaddr got=%h exp=0", {irom_addr, iram_rd_addr, iram_wr_addr, iram_wr_data});
        end
        rst = 1'b0;
    endtask

    task automatic test_int_fetch();
        @(posedge clk); #1;
        ea_n = 1'b1;
        bus.rom_en = 1'b1;
        bus.rom_addr = 16'h0FFF;
        #1;
        total++;
        if ({irom_en, irom_addr} !== {1'b1, 12'hFFF}) begin
            bad++; $display("FAIL int_fetch_c0 got=%h exp=%h", {irom_en, irom_addr}, {1'b1, 12'hFFF});
        end
        @(posedge clk); #1;
        total++;
        if ({bus.rom_ready, bus.rom_data, psen_n} !== {1'b1, rom_fn(12'hFFF), 1'b1}) begin
            bad++; $display("FAIL int_fetch_c1 got=%h exp=%h", {bus.rom_ready, bus.rom_data, psen_n}, {1'b1, rom_fn(12'hFFF), 1'b1});
        end
        bus.rom_en = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.rom_ready !== 1'b0) begin
            bad++; $display("FAIL int_fetch_pulse got=%b exp=0", bus.rom_ready);
        end
    endtask

    task automatic test_ext_fetch();
        logic [8:1] ale_v, psen_v, rdy_v;
        logic [7:0] p0_c1, p2_c1, got;
        ale_v = '0; psen_v = '0; rdy_v = '0; p0_c1 = '0; p2_c1 = '0; got = '0;
        @(posedge clk); #1;
        ea_n = 1'b1;
        bus.rom_en = 1'b1;
        bus.rom_addr = 16'h1000;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            ale_v[i] = ale;
            psen_v[i] = !psen_n;
            rdy_v[i] = bus.rom_ready;
            if (i == 1) begin p0_c1 = p0_out; p2_c1 = p2_out; end
            if (bus.rom_ready) begin got = bus.rom_data; bus.rom_en = 1'b0; end
        end
        total++;
        if (ale_v !== 8'b0000_0001) begin bad++; $display("FAIL ext_fetch_ale got=%b exp=00000001", ale_v); end
        total++;
        if ({p0_c1, p2_c1} !== 16'h0010) begin bad++; $display("FAIL ext_fetch_addr got=%h exp=0010", {p0_c1, p2_c1}); end
        total++;
        if (psen_v !== 8'b0000_1110) begin bad++; $display("FAIL ext_fetch_psen got=%b exp=00001110", psen_v); end
        total++;
        if (rdy_v !== 8'b0001_0000) begin bad++; $display("FAIL ext_fetch_ready got=%b exp=00010000", rdy_v); end
        total++;
        if (got !== ref_ext_rd(16'h1000)) begin bad++; $display("FAIL ext_fetch_data got=%h exp=%h", got, ref_ext_rd(16'h1000)); end
    endtask

    task automatic test_ea_low();
        logic [7:0] got;
        int lat_c, s0;
        s0 = irom_seen;
        ea_n = 1'b0;
        do_acc(0, 16'h0000, 8'h00, got, lat_c);
        ea_n = 1'b1;
        total++;
        if (lat_c !== 3 + W) begin bad++; $display("FAIL ea_low_lat got=%0d exp=%0d", lat_c, 3 + W); end
        total++;
        if (got !== ref_ext_rd(16'h0000)) begin bad++; $display("FAIL ea_low_data got=%h exp=%h", got, ref_ext_rd(16'h0000)); end
        total++;
        if (irom_seen - s0 !== 0) begin bad++; $display("FAIL ea_low_irom got=%0d exp=0", irom_seen - s0); end
    endtask

    task automatic test_simultaneous();
        int wr_rdy, rd_rdy, first_rd, wr_low, wr_bad;
        logic [7:0] got, got2;
        int lat_c;
        wr_rdy = 0; rd_rdy = 0; first_rd = 0; wr_low = 0; wr_bad = 0; got = '0;
        @(posedge clk); #1;
        bus.ram_wr_en = 1'b1; bus.ram_wr_addr = 16'h2000; bus.ram_wr_data = 8'hA5;
        bus.ram_rd_en = 1'b1; bus.ram_rd_addr = 16'h3000;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (!wr_n) begin
                wr_low++;
                if (p0_out !== 8'hA5 || p0_oe !== 1'b1) wr_bad++;
            end
            if (!rd_n && first_rd == 0) first_rd = i;
            if (bus.ram_wr_ready) begin wr_rdy = i; bus.ram_wr_en = 1'b0; end
            if (bus.ram_rd_ready) begin rd_rdy = i; got = bus.ram_rd_data; bus.ram_rd_en = 1'b0; break; end
        end
        bus.ram_rd_en = 1'b0;
        ref_ext[16'h2000] = 8'hA5;
        total++;
        if ({wr_rdy, wr_low, wr_bad} !== {32'd3 + W, 32'd1 + W, 32'd0}) begin
            bad++; $display("FAIL simul_write got=%0d/%0d/%0d exp=%0d/%0d/0", wr_rdy, wr_low, wr_bad, 3 + W, 1 + W);
        end
        total++;
        if ({first_rd, rd_rdy} !== {32'd6 + W, 32'd6 + 2 * W + 1}) begin
            bad++; $display("FAIL simul_read_timing got=%0d/%0d exp=%0d/%0d", first_rd, rd_rdy, 6 + W, 2 * W + 7);
        end
        total++;
        if (got !== ref_ext_rd(16'h3000)) begin bad++; $display("FAIL simul_read_data got=%h exp=%h", got, ref_ext_rd(16'h3000)); end
        do_acc(1, 16'h2000, 8'h00, got2, lat_c);
        total++;
        if (got2 !== 8'hA5) begin bad++; $display("FAIL simul_readback got=%h exp=a5", got2); end
    endtask

    task automatic test_w0();
        int lat_c, low;
        logic [7:0] got;
        lat_c = 0; low = 0; got = '0;
        @(posedge clk); #1;
        b0.ram_rd_en = 1'b1;
        b0.ram_rd_addr = 16'h4321;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (!z_rd_n) low++;
            if (b0.ram_rd_ready && lat_c == 0) begin lat_c = i; got = b0.ram_rd_data; b0.ram_rd_en = 1'b0; end
        end
        b0.ram_rd_en = 1'b0;
        total++;
        if ({lat_c, low} !== {32'd3, 32'd1}) begin bad++; $display("FAIL w0_timing got=%0d/%0d exp=3/1", lat_c, low); end
        total++;
        if (got !== ext_fn(16'h4321)) begin bad++; $display("FAIL w0_data got=%h exp=%h", got, ext_fn(16'h4321)); end
    endtask

    task automatic test_rst_mid();
        int found, spur, lat_c;
        logic [7:0] got;
        found = 0; spur = 0;
        @(posedge clk); #1;
        bus.ram_rd_en = 1'b1;
        bus.ram_rd_addr = 16'h0500;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (!rd_n) begin found = 1; break; end
        end
        total++;
        if (found !== 1) begin bad++; $display("FAIL rst_mid_strobe got=%0d exp=1", found); end
        rst = 1'b1;
        bus.ram_rd_en = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({psen_n, rd_n, wr_n, ale, p0_oe, bus.ram_rd_ready, bus.busy} !== 7'b1110000) begin
            bad++; $display("FAIL rst_mid_state got=%b exp=1110000", {psen_n, rd_n, wr_n, ale, p0_oe, bus.ram_rd_ready, bus.busy});
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.rom_ready || bus.ram_rd_ready || bus.ram_wr_ready) spur++;
        end
        total++;
        if (spur !== 0) begin bad++; $display("FAIL rst_mid_spurious got=%0d exp=0", spur); end
        do_acc(1, 16'h0500, 8'h00, got, lat_c);
        total++;
        if ({lat_c, got} !== {3 + W, ref_ext_rd(16'h0500)}) begin
            bad++; $display("FAIL rst_mid_fresh got=%0d/%h exp=%0d/%h", lat_c, got, 3 + W, ref_ext_rd(16'h0500));
        end
    endtask

    task automatic test_wrap();
        logic [7:0] got;
        int lat_c;
        do_acc(2, 16'hFFFF, 8'h77, got, lat_c);
        ref_ext[16'hFFFF] = 8'h77;
        total++;
        if (lat_c !== 3 + W) begin bad++; $display("FAIL wrap_write_lat got=%0d exp=%0d", lat_c, 3 + W); end
        do_acc(1, 16'hFFFF, 8'h00, got, lat_c);
        total++;
        if ({lat_c, got} !== {3 + W, 8'h77}) begin bad++; $display("FAIL wrap_read got=%0d/%h exp=%0d/77", lat_c, got, 3 + W); end
    endtask

    task automatic test_random();
        logic [15:0] edges [6];
        logic [15:0] a;
        logic [7:0]  d, got, exp_d;
        logic        internal;
        int kind, lat_c, exp_lat;
        edges = '{16'h00FF, 16'h0100, 16'h0FFF, 16'h1000, 16'hFFFF, 16'h0000};
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 2);
            ea_n = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = 16'($urandom_range(0, 255));
                1: a = 16'($urandom_range(256, 4095));
                2: a = 16'($urandom_range(4096, 65535));
                default: a = edges[$urandom_range(0, 5)];
            endcase
            d = 8'($urandom);
            internal = kind == 0 ? (ea_n && a < 16'h1000) : a < 16'h0100;
            exp_lat = internal ? 1 : 3 + W;
            exp_d = kind == 0 ? (internal ? rom_fn(a[11:0]) : ref_ext_rd(a)) :
                    (internal ? ref_iram[a[7:0]] : ref_ext_rd(a));
            do_acc(kind, a, d, got, lat_c);
            total++;
            if (lat_c !== exp_lat) begin bad++; $display("FAIL rand_lat kind=%0d addr=%h got=%0d exp=%0d", kind, a, lat_c, exp_lat); end
            if (kind != 2) begin
                total++;
                if (got !== exp_d) begin bad++; $display("FAIL rand_data kind=%0d addr=%h got=%h exp=%h", kind, a, got, exp_d); end
            end else if (internal)
                ref_iram[a[7:0]] = d;
            else
                ref_ext[a] = d;
        end
        ea_n = 1'b1;
    endtask

    task automatic test_protocol();
        total++;
        if (ovl !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d exp=0", ovl); end
    endtask

    initial begin
        bus.rom_en = 1'b0; bus.rom_addr = '0;
        bus.ram_rd_en = 1'b0; bus.ram_rd_addr = '0;
        bus.ram_wr_en = 1'b0; bus.ram_wr_addr = '0; bus.ram_wr_data = '0;
        b0.rom_en = 1'b0; b0.rom_addr = '0;
        b0.ram_rd_en = 1'b0; b0.ram_rd_addr = '0;
        b0.ram_wr_en = 1'b0; b0.ram_wr_addr = '0; b0.ram_wr_data = '0;
        ea_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            iram[i] = 8'(i) ^ 8'h99;
            ref_iram[i] = 8'(i) ^ 8'h99;
        end
        for (int i = 0; i < 65536; i++) ext_mem[i] = ext_fn(16'(i));
        test_reset();
        test_int_fetch();
        test_ext_fetch();
        test_ea_low();
        test_simultaneous();
        test_w0();
        test_rst_mid();
        test_wrap();
        test_random();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
